// File: rtl/utlp_pkg.sv
// Shared types and header constants for the PCIe completion path.
// Holds the request descriptor, the completer FSM states and the completion header DW builders.
package utlp_pkg;

  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [4:0] TYPE_CPL       = 5'b01010;
  localparam logic [2:0] CPL_SC         = 3'b000;
  localparam logic [2:0] CPL_UR         = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    BEAT0 = 2'd2,
    BEAT1 = 2'd3
  } cpl_state_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic [15:0] requester_id;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [3:0]  first_be;
    logic [31:0] addr;
  } cpl_req_t;

  // DW0: fmt/type, TC, TD=EP=0, attr, AT=0, length
  function automatic logic [31:0] cpl_dw0(input logic [2:0] fmt, input logic [2:0] tc,
                                          input logic [1:0] attr, input logic [9:0] len);
    cpl_dw0 = {fmt, TYPE_CPL, 1'b0, tc, 4'b0000, 1'b0, 1'b0, attr, 2'b00, len};
  endfunction

  function automatic logic [31:0] cpl_dw1(input logic [15:0] cid, input logic [2:0] status,
                                          input logic [11:0] byte_count);
    cpl_dw1 = {cid, status, 1'b0, byte_count};
  endfunction

  function automatic logic [31:0] cpl_dw2(input logic [15:0] rid, input logic [7:0] tag,
                                          input logic [6:0] lower_addr);
    cpl_dw2 = {rid, tag, 1'b0, lower_addr};
  endfunction

endpackage

// File: rtl/cpl_be_decode.sv
// First-DW byte-enable decode for completion headers.
// Yields the completion byte count and the byte offset of the first enabled byte.
module cpl_be_decode
  import utlp_pkg::*;
(
  input  logic [3:0]  first_be,
  output logic [11:0] byte_count,
  output logic [1:0]  lower_bits
);

  // byte count spans from the lowest to the highest enabled byte
  always_comb begin
    byte_count = 12'd1;
    casez (first_be)
      4'b1??1:                   byte_count = 12'd4;
      4'b01?1, 4'b1?10:          byte_count = 12'd3;
      4'b0011, 4'b0110, 4'b1100: byte_count = 12'd2;
      default:                   byte_count = 12'd1;
    endcase
  end

  // index of the lowest enabled byte; an empty mask points at byte 0
  always_comb begin
    lower_bits = 2'd0;
    casez (first_be)
      4'b???1: lower_bits = 2'd0;
      4'b??10: lower_bits = 2'd1;
      4'b?100: lower_bits = 2'd2;
      4'b1000: lower_bits = 2'd3;
      default: lower_bits = 2'd0;
    endcase
  end

endmodule

// File: rtl/tlp_cpl_tx.sv
// Completion transmitter: answers single-DW memory reads with CplD, anything else with UR Cpl.
// Every AXI-Stream output is registered from the next-state view so beats hold steady under backpressure.
module tlp_cpl_tx
  import utlp_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 10
) (
  input  logic                      user_clk,
  input  logic                      user_reset,
  input  logic [15:0]               cfg_completer_id,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [7:0]                req_tag,
  input  logic [15:0]               req_requester_id,
  input  logic [2:0]                req_tc,
  input  logic [1:0]                req_attr,
  input  logic [9:0]                req_len,
  input  logic [3:0]                req_first_be,
  input  logic [31:0]               req_addr,
  output logic                      rd_en,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]               rd_data,
  output logic [63:0]               s_axis_tx_tdata,
  output logic [7:0]                s_axis_tx_tkeep,
  output logic                      s_axis_tx_tlast,
  output logic                      s_axis_tx_tvalid,
  input  logic                      s_axis_tx_tready,
  output logic [3:0]                s_axis_tx_tuser
);

  cpl_state_t state_r, state_next_s;
  cpl_req_t   req_r, req_in_s;

  logic [31:0]               data_r, data_word_s;
  logic                      capture_pending_r;
  logic [63:0]               tdata_r, tdata_next_s;
  logic [7:0]                tkeep_r, tkeep_next_s;
  logic                      tlast_r, tlast_next_s;
  logic                      tvalid_r, tvalid_next_s;
  logic                      rd_en_r, rd_en_next_s;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_r;
  logic                      accept_s, beat_hs_s, len_one_s;
  logic [11:0]               byte_count_s;
  logic [1:0]                lower_bits_s;
  logic [31:0]               dw0_s, dw1_s, dw2_s;
  logic                      unused_addr_s;

  assign req_in_s  = {req_tag, req_requester_id, req_tc, req_attr, req_len, req_first_be, req_addr};
  assign req_ready = (state_r == IDLE) && !user_reset;
  assign accept_s  = req_valid && req_ready;
  assign beat_hs_s = tvalid_r && s_axis_tx_tready;
  assign len_one_s = (req_r.len == 10'd1);

  // only the DW-offset bits of the latched address feed the header
  assign unused_addr_s = ^{req_r.addr[31:7], req_r.addr[1:0]};

  cpl_be_decode u_be_decode (
    .first_be   (req_r.first_be),
    .byte_count (byte_count_s),
    .lower_bits (lower_bits_s)
  );

  // header DWs for a successful CplD or an unsupported-request Cpl
  always_comb begin
    dw0_s = 32'h0;
    dw1_s = 32'h0;
    dw2_s = 32'h0;
    if (len_one_s) begin
      dw0_s = cpl_dw0(FMT_3DW_DATA, req_r.tc, req_r.attr, 10'd1);
      dw1_s = cpl_dw1(cfg_completer_id, CPL_SC, byte_count_s);
      dw2_s = cpl_dw2(req_r.requester_id, req_r.tag, {req_r.addr[6:2], lower_bits_s});
    end else begin
      dw0_s = cpl_dw0(FMT_3DW_NODATA, req_r.tc, req_r.attr, 10'd0);
      dw1_s = cpl_dw1(cfg_completer_id, CPL_UR, 12'd4);
      dw2_s = cpl_dw2(req_r.requester_id, req_r.tag, 7'd0);
    end
  end

  // on the first BEAT0 cycle the read data is still on the bus, afterwards it is held locally
  always_comb begin
    data_word_s = data_r;
    if (capture_pending_r) begin
      data_word_s = rd_data;
    end else begin
      data_word_s = data_r;
    end
  end

  // next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_next_s = READ;
        else           state_next_s = IDLE;
      end
      READ: state_next_s = BEAT0;
      BEAT0: begin
        if (beat_hs_s) state_next_s = BEAT1;
        else           state_next_s = BEAT0;
      end
      BEAT1: begin
        if (beat_hs_s) state_next_s = IDLE;
        else           state_next_s = BEAT1;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // output values for the state being entered, registered below
  always_comb begin
    tvalid_next_s = 1'b0;
    tdata_next_s  = 64'h0;
    tkeep_next_s  = 8'h00;
    tlast_next_s  = 1'b0;
    rd_en_next_s  = accept_s && (req_len == 10'd1);
    case (state_next_s)
      BEAT0: begin
        tvalid_next_s = 1'b1;
        tdata_next_s  = {dw1_s, dw0_s};
        tkeep_next_s  = 8'hFF;
        tlast_next_s  = 1'b0;
      end
      BEAT1: begin
        tvalid_next_s = 1'b1;
        tlast_next_s  = 1'b1;
        if (len_one_s) begin
          tdata_next_s = {data_word_s, dw2_s};
          tkeep_next_s = 8'hFF;
        end else begin
          tdata_next_s = {32'h0, dw2_s};
          tkeep_next_s = 8'h0F;
        end
      end
      default: begin
        tvalid_next_s = 1'b0;
        tdata_next_s  = 64'h0;
        tkeep_next_s  = 8'h00;
        tlast_next_s  = 1'b0;
      end
    endcase
  end

  // state, descriptor and read-data registers
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_r           <= IDLE;
      req_r             <= '0;
      data_r            <= 32'h0;
      capture_pending_r <= 1'b0;
    end else begin
      state_r           <= state_next_s;
      capture_pending_r <= (state_r == READ);
      if (accept_s) begin
        req_r <= req_in_s;
      end
      if (capture_pending_r) begin
        data_r <= rd_data;
      end
    end
  end

  // registered interface outputs
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      tvalid_r  <= 1'b0;
      tdata_r   <= 64'h0;
      tkeep_r   <= 8'h00;
      tlast_r   <= 1'b0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= {REG_ADDR_WIDTH{1'b0}};
    end else begin
      tvalid_r <= tvalid_next_s;
      tdata_r  <= tdata_next_s;
      tkeep_r  <= tkeep_next_s;
      tlast_r  <= tlast_next_s;
      rd_en_r  <= rd_en_next_s;
      if (accept_s) begin
        rd_addr_r <= req_addr[REG_ADDR_WIDTH+1:2];
      end
    end
  end

  assign s_axis_tx_tvalid = tvalid_r;
  assign s_axis_tx_tdata  = tdata_r;
  assign s_axis_tx_tkeep  = tkeep_r;
  assign s_axis_tx_tlast  = tlast_r;
  assign s_axis_tx_tuser  = 4'b0000;
  assign rd_en            = rd_en_r;
  assign rd_addr          = rd_addr_r;

endmodule

// File: tb/tb_tlp_cpl_tx.sv
// Directed self-checking bench for tlp_cpl_tx with a one-cycle-latency register file model.
module tb_tlp_cpl_tx;

  logic        user_clk;
  logic        user_reset;
  logic [15:0] cfg_completer_id;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_tag;
  logic [15:0] req_requester_id;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [9:0]  req_len;
  logic [3:0]  req_first_be;
  logic [31:0] req_addr;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast;
  logic        s_axis_tx_tvalid;
  logic        s_axis_tx_tready;
  logic [3:0]  s_axis_tx_tuser;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cnt = 0;
  logic [63:0] hs_data [0:63];

  tlp_cpl_tx #(.REG_ADDR_WIDTH(10)) dut (
    .user_clk         (user_clk),
    .user_reset       (user_reset),
    .cfg_completer_id (cfg_completer_id),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_tag          (req_tag),
    .req_requester_id (req_requester_id),
    .req_tc           (req_tc),
    .req_attr         (req_attr),
    .req_len          (req_len),
    .req_first_be     (req_first_be),
    .req_addr         (req_addr),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tready (s_axis_tx_tready),
    .s_axis_tx_tuser  (s_axis_tx_tuser)
  );

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  // register file: data one cycle after the strobe, junk otherwise
  always @(posedge user_clk) begin
    if (rd_en) begin
      if (rd_addr == 10'd4) rd_data <= 32'hDEADBEEF;
      else                  rd_data <= {16'hCAFE, 6'd0, rd_addr};
    end else begin
      rd_data <= 32'h0BADF00D;
    end
  end

  // cycle counter and handshake log
  always @(posedge user_clk) begin
    cyc <= cyc + 1;
    if (s_axis_tx_tvalid && s_axis_tx_tready) begin
      if (hs_cnt < 64) hs_data[hs_cnt] <= s_axis_tx_tdata;
      hs_cnt <= hs_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge user_clk);
    #1;
  endtask

  task automatic set_req(input logic [7:0] tag, input logic [2:0] tc, input logic [1:0] attr,
                         input logic [9:0] len, input logic [3:0] be, input logic [31:0] addr);
    req_tag = tag; req_requester_id = 16'h0100; req_tc = tc; req_attr = attr;
    req_len = len; req_first_be = be; req_addr = addr;
  endtask

  // leaves the caller in the window right after the accept edge
  task automatic accept_req;
    int w;
    w = 0;
    req_valid = 1'b1;
    while (!req_ready && w < 20) begin
      tick;
      w++;
    end
    tick;
    req_valid = 1'b0;
  endtask

  task automatic run_cpl(input logic [7:0] tag, input logic [2:0] tc, input logic [1:0] attr,
                         input logic [9:0] len, input logic [3:0] be, input logic [31:0] addr,
                         output logic [63:0] d0, output logic [7:0] k0, output logic l0,
                         output logic [63:0] d1, output logic [7:0] k1, output logic l1,
                         output int rd_cnt, output int rd_lat, output int tv_lat,
                         output int nbeats, output logic [9:0] ra);
    set_req(tag, tc, attr, len, be, addr);
    s_axis_tx_tready = 1'b1;
    accept_req();
    d0 = 64'h0; k0 = 8'h00; l0 = 1'b0; d1 = 64'h0; k1 = 8'h00; l1 = 1'b0;
    rd_cnt = 0; rd_lat = -1; tv_lat = -1; nbeats = 0; ra = 10'h0;
    for (int c = 1; c <= 12 && nbeats < 2; c++) begin
      if (rd_en) begin
        rd_cnt++;
        if (rd_lat < 0) rd_lat = c;
        ra = rd_addr;
      end
      if (s_axis_tx_tvalid) begin
        if (tv_lat < 0) tv_lat = c;
        if (nbeats == 0) begin
          d0 = s_axis_tx_tdata; k0 = s_axis_tx_tkeep; l0 = s_axis_tx_tlast;
        end else begin
          d1 = s_axis_tx_tdata; k1 = s_axis_tx_tkeep; l1 = s_axis_tx_tlast;
        end
        nbeats++;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    user_reset = 1'b1;
    repeat (3) tick;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_during: got %b want 0", req_ready);
    end
    n_cmp++;
    if ({s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata} !== 74'h0) begin
      n_fail++; $display("FAIL reset_axis: got v%b l%b k%h d%h want all 0", s_axis_tx_tvalid,
                         s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata);
    end
    n_cmp++;
    if ({rd_en, rd_addr, s_axis_tx_tuser} !== 15'h0) begin
      n_fail++; $display("FAIL reset_rd: got en%b addr%h user%h want 0", rd_en, rd_addr, s_axis_tx_tuser);
    end
    user_reset = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after: got %b want 1", req_ready);
    end
    n_cmp++;
    if (s_axis_tx_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_tvalid_after: got %b want 0", s_axis_tx_tvalid);
    end
  endtask

  task automatic test_single_cpld;
    logic [63:0] d0, d1; logic [7:0] k0, k1; logic l0, l1; int rc, rl, tl, nb; logic [9:0] ra;
    run_cpl(8'h12, 3'd0, 2'd0, 10'd1, 4'hF, 32'h0000_0010, d0, k0, l0, d1, k1, l1, rc, rl, tl, nb, ra);
    n_cmp++;
    if (rc !== 1 || rl !== 1) begin
      n_fail++; $display("FAIL single_rd_en: got count %0d at +%0d want 1 at +1", rc, rl);
    end
    n_cmp++;
    if (ra !== 10'd4) begin
      n_fail++; $display("FAIL single_rd_addr: got %h want 004", ra);
    end
    n_cmp++;
    if (tl !== 2) begin
      n_fail++; $display("FAIL single_tvalid_latency: got %0d want 2", tl);
    end
    n_cmp++;
    if ({d0, k0, l0} !== {64'h03000004_4A000001, 8'hFF, 1'b0}) begin
      n_fail++; $display("FAIL single_beat0: got %h k%h l%b want 030000044a000001 kff l0", d0, k0, l0);
    end
    n_cmp++;
    if ({d1, k1, l1} !== {64'hDEADBEEF_01001210, 8'hFF, 1'b1}) begin
      n_fail++; $display("FAIL single_beat1: got %h k%h l%b want deadbeef01001210 kff l1", d1, k1, l1);
    end
    n_cmp++;
    if (nb !== 2 || s_axis_tx_tvalid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_end: beats %0d tvalid %b ready %b want 2 0 1", nb,
                         s_axis_tx_tvalid, req_ready);
    end
  endtask

  task automatic test_be_decode;
    logic [63:0] d0, d1; logic [7:0] k0, k1; logic l0, l1; int rc, rl, tl, nb; logic [9:0] ra;
    logic [3:0]  be_t  [0:2] = '{4'h6, 4'h8, 4'h0};
    logic [7:0]  tag_t [0:2] = '{8'h21, 8'h22, 8'h23};
    logic [2:0]  tc_t  [0:2] = '{3'd0, 3'd5, 3'd0};
    logic [1:0]  at_t  [0:2] = '{2'd0, 2'd2, 2'd0};
    logic [63:0] b0_t  [0:2] = '{64'h03000002_4A000001, 64'h03000001_4A502001, 64'h03000001_4A000001};
    logic [63:0] b1_t  [0:2] = '{64'hCAFE0009_01002125, 64'hCAFE0009_01002227, 64'hCAFE0009_01002324};
    for (int i = 0; i < 3; i++) begin
      run_cpl(tag_t[i], tc_t[i], at_t[i], 10'd1, be_t[i], 32'h0000_0024,
              d0, k0, l0, d1, k1, l1, rc, rl, tl, nb, ra);
      n_cmp++;
      if (d0 !== b0_t[i]) begin
        n_fail++; $display("FAIL be_beat0[%0d]: got %h want %h", i, d0, b0_t[i]);
      end
      n_cmp++;
      if (d1 !== b1_t[i]) begin
        n_fail++; $display("FAIL be_beat1[%0d]: got %h want %h", i, d1, b1_t[i]);
      end
      n_cmp++;
      if ({k1, l1} !== {8'hFF, 1'b1}) begin
        n_fail++; $display("FAIL be_keep_last[%0d]: got k%h l%b want kff l1", i, k1, l1);
      end
    end
  endtask

  task automatic test_unsupported_len;
    logic [63:0] d0, d1; logic [7:0] k0, k1; logic l0, l1; int rc, rl, tl, nb; logic [9:0] ra;
    logic [9:0]  len_t [0:1] = '{10'd2, 10'd0};
    logic [7:0]  tag_t [0:1] = '{8'h33, 8'h34};
    logic [63:0] b1_t  [0:1] = '{64'h00000000_01003300, 64'h00000000_01003400};
    for (int i = 0; i < 2; i++) begin
      run_cpl(tag_t[i], 3'd0, 2'd0, len_t[i], 4'hF, 32'h0000_0024,
              d0, k0, l0, d1, k1, l1, rc, rl, tl, nb, ra);
      n_cmp++;
      if (rc !== 0) begin
        n_fail++; $display("FAIL ur_rd_en[%0d]: got %0d reads want 0", i, rc);
      end
      n_cmp++;
      if ({d0, k0, l0} !== {64'h03002004_0A000000, 8'hFF, 1'b0}) begin
        n_fail++; $display("FAIL ur_beat0[%0d]: got %h k%h l%b want 030020040a000000 kff l0", i, d0, k0, l0);
      end
      n_cmp++;
      if ({d1, k1, l1} !== {b1_t[i], 8'h0F, 1'b1}) begin
        n_fail++; $display("FAIL ur_beat1[%0d]: got %h k%h l%b want %h k0f l1", i, d1, k1, l1, b1_t[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int hs_base;
    set_req(8'h5A, 3'd0, 2'd0, 10'd1, 4'hF, 32'h0000_0040);
    req_requester_id = 16'h0200;
    s_axis_tx_tready = 1'b0;
    accept_req();
    hs_base = hs_cnt;
    tick;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({s_axis_tx_tvalid, s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, req_ready} !==
          {1'b1, 64'h03000004_4A000001, 8'hFF, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL bp_beat0_hold[%0d]: got v%b %h k%h l%b rdy%b want v1 030000044a000001 kff l0 rdy0",
                           i, s_axis_tx_tvalid, s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, req_ready);
      end
      tick;
    end
    s_axis_tx_tready = 1'b1;
    tick;
    s_axis_tx_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({s_axis_tx_tvalid, s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, req_ready} !==
          {1'b1, 64'hCAFE0010_02005A40, 8'hFF, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL bp_beat1_hold[%0d]: got v%b %h k%h l%b rdy%b want v1 cafe001002005a40 kff l1 rdy0",
                           i, s_axis_tx_tvalid, s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, req_ready);
      end
      tick;
    end
    s_axis_tx_tready = 1'b1;
    tick;
    n_cmp++;
    if ({req_ready, s_axis_tx_tvalid} !== 2'b10) begin
      n_fail++; $display("FAIL bp_end: got ready %b tvalid %b want 1 0", req_ready, s_axis_tx_tvalid);
    end
    n_cmp++;
    if (hs_cnt - hs_base !== 2) begin
      n_fail++; $display("FAIL bp_handshakes: got %0d want 2", hs_cnt - hs_base);
    end
  endtask

  task automatic test_back_to_back;
    int acc [0:2];
    int hs_base, w;
    logic [7:0]  tag_t [0:2] = '{8'hA1, 8'hB2, 8'hC3};
    logic [31:0] adr_t [0:2] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    logic [63:0] b1_t  [0:2] = '{64'hCAFE0040_0100A100, 64'hCAFE0041_0100B204, 64'hCAFE0042_0100C308};
    s_axis_tx_tready = 1'b1;
    hs_base = hs_cnt;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(tag_t[i], 3'd0, 2'd0, 10'd1, 4'hF, adr_t[i]);
      w = 0;
      while (!req_ready && w < 20) begin
        tick;
        w++;
      end
      acc[i] = cyc;
      tick;
    end
    req_valid = 1'b0;
    w = 0;
    while (hs_cnt - hs_base < 6 && w < 20) begin
      tick;
      w++;
    end
    n_cmp++;
    if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d,%0d want 4,4", acc[1] - acc[0], acc[2] - acc[1]);
    end
    n_cmp++;
    if (hs_cnt - hs_base !== 6) begin
      n_fail++; $display("FAIL b2b_handshakes: got %0d want 6", hs_cnt - hs_base);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (hs_data[hs_base + 2*i + 1] !== b1_t[i]) begin
        n_fail++; $display("FAIL b2b_beat1[%0d]: got %h want %h", i, hs_data[hs_base + 2*i + 1], b1_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid_tlp;
    logic [63:0] d0, d1; logic [7:0] k0, k1; logic l0, l1; int rc, rl, tl, nb; logic [9:0] ra;
    set_req(8'h77, 3'd0, 2'd0, 10'd1, 4'hF, 32'h0000_0040);
    s_axis_tx_tready = 1'b0;
    accept_req();
    tick;
    s_axis_tx_tready = 1'b1;
    tick;
    s_axis_tx_tready = 1'b0;
    n_cmp++;
    if ({s_axis_tx_tvalid, s_axis_tx_tlast} !== 2'b11) begin
      n_fail++; $display("FAIL rst_mid_in_beat1: got v%b l%b want v1 l1", s_axis_tx_tvalid, s_axis_tx_tlast);
    end
    tick;
    user_reset = 1'b1;
    tick;
    n_cmp++;
    if ({s_axis_tx_tvalid, s_axis_tx_tlast, req_ready} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_outputs: got v%b l%b rdy%b want 000", s_axis_tx_tvalid,
                         s_axis_tx_tlast, req_ready);
    end
    user_reset = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ready_after: got %b want 1", req_ready);
    end
    run_cpl(8'h99, 3'd0, 2'd0, 10'd1, 4'hF, 32'h0000_0010, d0, k0, l0, d1, k1, l1, rc, rl, tl, nb, ra);
    n_cmp++;
    if (d0 !== 64'h03000004_4A000001 || d1 !== 64'hDEADBEEF_01009910) begin
      n_fail++; $display("FAIL rst_mid_next_cpl: got %h %h want 030000044a000001 deadbeef01009910", d0, d1);
    end
    n_cmp++;
    if ({nb == 2, tl == 2, k1, l1} !== {1'b1, 1'b1, 8'hFF, 1'b1}) begin
      n_fail++; $display("FAIL rst_mid_next_shape: got beats %0d lat %0d k%h l%b want 2 2 kff l1", nb, tl, k1, l1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    user_reset = 1'b1;
    cfg_completer_id = 16'h0300;
    req_valid = 1'b0;
    s_axis_tx_tready = 1'b0;
    set_req(8'h00, 3'd0, 2'd0, 10'd0, 4'h0, 32'h0);
    test_reset();
    test_single_cpld();
    test_be_decode();
    test_unsupported_len();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_tlp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
